// File: rtl/perf_monitor_pkg.sv
// Shared types and constants for the pipeline performance / halt monitor.
//   state_t      : monitor FSM states (RUN, DRAIN, DONE)
//   IDX_*        : fixed counter slots in the counter map
//   HALT_INSN_DEFAULT : self-loop "jal x0,0" used as the halt marker
package perf_monitor_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned IDX_CYCLE = 0;
  localparam int unsigned IDX_RET   = 1;
  localparam int unsigned IDX_BUB   = 2;
  localparam int unsigned IDX_EVT0  = 3;

  localparam logic [31:0] HALT_INSN_DEFAULT = 32'h0000_006f;

endpackage

// File: rtl/perf_counter.sv
// Single event counter with sticky overflow flag.
//   clk, rst (async, active-high), clr (sync clear), inc (increment strobe)
//   value : current count
//   ovf   : set by an increment from all-ones, held until clr/rst
// SATURATE=1 pins the count at all-ones on overflow, SATURATE=0 wraps to 0.
module perf_counter #(
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (&value) begin
        ovf   <= 1'b1;
        value <= SATURATE ? value : '0;
      end else begin
        value <= value + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// Pipeline performance and halt monitor for the pipelined RV32I cores.
// Counts cycles, retired instructions, bubbles and NUM_EVT generic events;
// on fetching HALT_INSN it drains for HALT_HOLD cycles, then freezes.
//   i_clk, i_rst (async, active-high), i_en (count enable), i_clr (sync clear)
//   i_insn_vld : retire valid (0 = bubble)   i_if_instr : fetch word
//   i_evt      : event strobes               i_rd_sel   : counter select
//   o_rd_data  : selected counter (1-cycle latency, 0 if select out of range)
//   o_ovf      : sticky overflow per counter
//   o_halted   : DRAIN or DONE               o_done     : DONE
module perf_monitor
  import perf_monitor_pkg::*;
#(
  parameter int unsigned  CNT_W     = 32,
  parameter int unsigned  NUM_EVT   = 4,
  parameter logic [31:0]  HALT_INSN = HALT_INSN_DEFAULT,
  parameter int unsigned  HALT_HOLD = 4,
  parameter bit           SATURATE  = 1'b1,
  localparam int unsigned NUM_CNT   = NUM_EVT + 3,
  localparam int unsigned SEL_W     = $clog2(NUM_CNT)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_clr,
  input  logic               i_insn_vld,
  input  logic [31:0]        i_if_instr,
  input  logic [NUM_EVT-1:0] i_evt,
  input  logic [SEL_W-1:0]   i_rd_sel,
  output logic [CNT_W-1:0]   o_rd_data,
  output logic [NUM_CNT-1:0] o_ovf,
  output logic               o_halted,
  output logic               o_done
);

  localparam int unsigned DRN_W    = (HALT_HOLD > 1) ? $clog2(HALT_HOLD) : 1;
  localparam int unsigned RD_DEPTH = 1 << SEL_W;

  state_t             state, state_nxt;
  logic [DRN_W-1:0]   drn_cnt, drn_nxt;
  logic               halted_c, done_c;
  logic               cnt_en;
  logic [NUM_CNT-1:0] inc;
  logic [CNT_W-1:0]   cnt_val [NUM_CNT];
  logic [CNT_W-1:0]   rd_mux  [RD_DEPTH];

  // Counting is allowed while running or draining; DONE freezes everything.
  assign cnt_en = i_en & (state != DONE);

  assign inc[IDX_CYCLE]             = cnt_en;
  assign inc[IDX_RET]               = cnt_en & i_insn_vld;
  assign inc[IDX_BUB]               = cnt_en & ~i_insn_vld;
  assign inc[IDX_EVT0 +: NUM_EVT]   = {NUM_EVT{cnt_en}} & i_evt;

  // Counter bank.
  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    perf_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk   (i_clk),
      .rst   (i_rst),
      .clr   (i_clr),
      .inc   (inc[g]),
      .value (cnt_val[g]),
      .ovf   (o_ovf[g])
    );
  end

  // Read mux padded to a power of two so unused selects read 0.
  for (genvar g = 0; g < RD_DEPTH; g++) begin : g_rd
    if (g < NUM_CNT) begin : g_live
      assign rd_mux[g] = cnt_val[g];
    end else begin : g_pad
      assign rd_mux[g] = '0;
    end
  end

  // Read register: samples the pre-increment value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rd_data <= '0;
    end else begin
      o_rd_data <= rd_mux[i_rd_sel];
    end
  end

  // FSM state register plus registered status decodes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= RUN;
      drn_cnt  <= '0;
      o_halted <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      state    <= state_nxt;
      drn_cnt  <= drn_nxt;
      o_halted <= halted_c;
      o_done   <= done_c;
    end
  end

  // Next state: clear wins; drain ignores i_en so a halt always completes.
  always_comb begin
    state_nxt = state;
    drn_nxt   = drn_cnt;
    if (i_clr) begin
      state_nxt = RUN;
      drn_nxt   = '0;
    end else begin
      case (state)
        RUN: begin
          if (i_en && (i_if_instr == HALT_INSN)) begin
            state_nxt = DRAIN;
            drn_nxt   = DRN_W'(HALT_HOLD - 1);
          end
        end
        DRAIN: begin
          if (drn_cnt == '0) begin
            state_nxt = DONE;
          end else begin
            drn_nxt = drn_cnt - DRN_W'(1);
          end
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = RUN;
      endcase
    end
  end

  // Status decodes of the next state, registered above.
  always_comb begin
    halted_c = 1'b0;
    done_c   = 1'b0;
    if (state_nxt != RUN) halted_c = 1'b1;
    if (state_nxt == DONE) done_c  = 1'b1;
  end

endmodule

// File: tb/tb_perf_monitor.sv
module tb_perf_monitor;

  localparam int          NCNT = 7;
  localparam int          HOLD = 4;
  localparam logic [31:0] HALT = 32'h0000_006f;

  logic        i_clk, i_rst, i_en, i_clr, i_insn_vld;
  logic [31:0] i_if_instr;
  logic [3:0]  i_evt;
  logic [2:0]  i_rd_sel;

  logic [31:0] rd_m;
  logic [3:0]  rd_s, rd_w;
  logic [6:0]  ovf_m, ovf_s, ovf_w;
  logic        hlt_m, hlt_s, hlt_w, dn_m, dn_s, dn_w;

  perf_monitor u_main (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_clr(i_clr),
    .i_insn_vld(i_insn_vld), .i_if_instr(i_if_instr), .i_evt(i_evt),
    .i_rd_sel(i_rd_sel), .o_rd_data(rd_m), .o_ovf(ovf_m),
    .o_halted(hlt_m), .o_done(dn_m)
  );

  perf_monitor #(.CNT_W(4), .SATURATE(1'b1)) u_sat4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_clr(i_clr),
    .i_insn_vld(i_insn_vld), .i_if_instr(i_if_instr), .i_evt(i_evt),
    .i_rd_sel(i_rd_sel), .o_rd_data(rd_s), .o_ovf(ovf_s),
    .o_halted(hlt_s), .o_done(dn_s)
  );

  perf_monitor #(.CNT_W(4), .SATURATE(1'b0)) u_wrap4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_clr(i_clr),
    .i_insn_vld(i_insn_vld), .i_if_instr(i_if_instr), .i_evt(i_evt),
    .i_rd_sel(i_rd_sel), .o_rd_data(rd_w), .o_ovf(ovf_w),
    .o_halted(hlt_w), .o_done(dn_w)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: unbounded "true" increment counts per slot, folded
  // into a finite counter by plain arithmetic.
  longint tcnt [NCNT];
  longint m_rd_t;
  bit     m_halted, m_done;
  int     m_since;

  function automatic longint fold(input longint t, input int w, input bit sat);
    longint mx;
    mx = (longint'(1) << w) - 1;
    if (t <= mx) return t;
    return sat ? mx : (t % (mx + 1));
  endfunction

  function automatic longint ovf_vec(input int w);
    longint v;
    v = 0;
    for (int i = 0; i < NCNT; i++)
      if (tcnt[i] > ((longint'(1) << w) - 1)) v |= (longint'(1) << i);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCNT; i++) tcnt[i] = 0;
    m_rd_t = 0; m_halted = 0; m_done = 0; m_since = 0;
  endtask

  task automatic model_step();
    m_rd_t = (int'(i_rd_sel) < NCNT) ? tcnt[i_rd_sel] : 0;
    if (i_clr) begin
      for (int i = 0; i < NCNT; i++) tcnt[i] = 0;
      m_halted = 0; m_done = 0; m_since = 0;
    end else begin
      if (i_en && !m_done) begin
        tcnt[0]++;
        if (i_insn_vld) tcnt[1]++; else tcnt[2]++;
        for (int k = 0; k < 4; k++) if (i_evt[k]) tcnt[3+k]++;
      end
      if (m_halted && !m_done) begin
        m_since++;
        if (m_since == HOLD) m_done = 1;
      end else if (!m_halted && i_en && i_if_instr == HALT) begin
        m_halted = 1;
        m_since  = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_step();
    #1;
  endtask

  task automatic check_all();
    check("model_rd_main",  longint'(rd_m),  fold(m_rd_t, 32, 1'b1));
    check("model_rd_sat4",  longint'(rd_s),  fold(m_rd_t, 4, 1'b1));
    check("model_rd_wrap4", longint'(rd_w),  fold(m_rd_t, 4, 1'b0));
    check("model_ovf_main", longint'(ovf_m), ovf_vec(32));
    check("model_ovf_sat4", longint'(ovf_s), ovf_vec(4));
    check("model_ovf_wrap4",longint'(ovf_w), ovf_vec(4));
    check("model_halted",   longint'(hlt_m), longint'(m_halted));
    check("model_done",     longint'(dn_m),  longint'(m_done));
    check("model_halted4",  longint'(hlt_w), longint'(m_halted));
    check("model_done4",    longint'(dn_s),  longint'(m_done));
  endtask

  typedef struct {
    logic        en;
    logic        vld;
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [31:0] exp_rd;
    logic        exp_halted;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // Counting table: 10 enabled cycles with vld 1,0,1,... then frozen reads.
    for (int i = 0; i < 10; i++)
      tbl[i] = '{1'b1, (i % 2 == 0), 32'h0, 3'd0, 32'(i), 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0, 3'd0, 32'd10, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 32'h0, 3'd1, 32'd5,  1'b0};
    tbl[12] = '{1'b0, 1'b0, 32'h0, 3'd2, 32'd5,  1'b0};
    tbl[13] = '{1'b0, 1'b0, 32'h0, 3'd7, 32'd0,  1'b0};
    tbl[14] = '{1'b0, 1'b0, HALT,  3'd0, 32'd10, 1'b0};

    i_rst = 1'b1; i_en = 1'b0; i_clr = 1'b0; i_insn_vld = 1'b0;
    i_if_instr = 32'h0; i_evt = 4'h0; i_rd_sel = 3'd0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check("reset_rd",     longint'(rd_m),  0);
    check("reset_ovf",    longint'(ovf_m), 0);
    check("reset_halted", longint'(hlt_m), 0);
    check("reset_done",   longint'(dn_m),  0);
    i_rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      i_en = tbl[i].en; i_insn_vld = tbl[i].vld;
      i_if_instr = tbl[i].instr; i_rd_sel = tbl[i].sel;
      tick();
      check($sformatf("tbl%0d_rd", i), longint'(rd_m), longint'(tbl[i].exp_rd));
      check($sformatf("tbl%0d_halted", i), longint'(hlt_m), longint'(tbl[i].exp_halted));
      check_all();
    end
    check("count_ovf", longint'(ovf_m), 0);

    // Clear on the same edge as a halt match.
    i_en = 1'b1; i_clr = 1'b1; i_if_instr = HALT; i_insn_vld = 1'b1; i_rd_sel = 3'd0;
    tick();
    check("clrhalt_halted", longint'(hlt_m), 0);
    check("clrhalt_done",   longint'(dn_m),  0);
    i_clr = 1'b0; i_en = 1'b0; i_if_instr = 32'h0;
    for (int s = 0; s < 3; s++) begin
      i_rd_sel = 3'(s);
      tick();
      check($sformatf("clr_rd%0d", s), longint'(rd_m), 0);
      check("clr_halted", longint'(hlt_m), 0);
    end
    check("clr_ovf", longint'(ovf_m), 0);

    // Halt on the 20th enabled edge, drain 4, then freeze.
    i_en = 1'b1; i_insn_vld = 1'b1; i_rd_sel = 3'd0;
    repeat (19) tick();
    i_if_instr = HALT;
    tick();
    check("halt_halted", longint'(hlt_m), 1);
    check("halt_done",   longint'(dn_m),  0);
    i_if_instr = 32'h0;
    tick();
    check("c20_rd_main",  longint'(rd_m), 20);
    check("c20_rd_sat4",  longint'(rd_s), 15);
    check("c20_rd_wrap4", longint'(rd_w), 4);
    check("c20_ovf0_sat4",  longint'(ovf_s[0]), 1);
    check("c20_ovf0_wrap4", longint'(ovf_w[0]), 1);
    i_if_instr = HALT;
    tick();
    check("drain_done_e22", longint'(dn_m), 0);
    i_if_instr = 32'h0;
    tick();
    check("drain_done_e23", longint'(dn_m), 0);
    check("drain_halted",   longint'(hlt_m), 1);
    tick();
    check("done_set",    longint'(dn_m),  1);
    check("done_halted", longint'(hlt_m), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("frozen_rd", longint'(rd_m), 24);
      check("frozen_done", longint'(dn_m), 1);
    end
    check("frozen_wrap4", longint'(rd_w), 8);
    check("frozen_sat4",  longint'(rd_s), 15);

    // Asynchronous reset in the middle of a drain.
    i_clr = 1'b1; i_en = 1'b0;
    tick();
    i_clr = 1'b0; i_en = 1'b1; i_if_instr = HALT;
    tick();
    i_if_instr = 32'h0;
    tick();
    tick();
    check("pre_rst_halted", longint'(hlt_m), 1);
    check("pre_rst_rd",     longint'(rd_m),  2);
    #1 i_rst = 1'b1;
    #1;
    check("async_rst_halted", longint'(hlt_m), 0);
    check("async_rst_done",   longint'(dn_m),  0);
    check("async_rst_rd",     longint'(rd_m),  0);
    check("async_rst_ovf",    longint'(ovf_w), 0);
    model_reset();
    #1 i_rst = 1'b0;

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      i_en       = ($urandom_range(0, 9) != 0);
      i_clr      = ($urandom_range(0, 59) == 0);
      i_insn_vld = 1'($urandom);
      i_if_instr = ($urandom_range(0, 24) == 0) ? HALT : $urandom;
      i_evt      = 4'($urandom);
      i_rd_sel   = 3'($urandom_range(0, 7));
      tick();
      check_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
